// File: rtl/bin_add_3x2.sv
// bin_add_3x2: registered three-operand adder, a + (en ? b : 0) + c.
// Define BIN_ADD_3X2_INREG_EN to register the inputs too (latency 2).
module bin_add_3x2 #(
   parameter int OP_WIDTH    = 16,
   parameter int CARRY_WIDTH = 1,
   parameter int SUM_WIDTH   = 17
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CARRY_WIDTH-1:0]        in_a,
   input  logic [OP_WIDTH-1:0]           in_b,
   input  logic [OP_WIDTH-1:0]           in_c,
   input  logic                          enable_bin,
   output logic [OP_WIDTH-1:0]           low_sum,
   output logic [SUM_WIDTH-OP_WIDTH-1:0] hi_sum
);

   if (SUM_WIDTH <= OP_WIDTH || CARRY_WIDTH > OP_WIDTH
       || CARRY_WIDTH < 1) begin : g_bad_cfg
      $error("bin_add_3x2: unsupported width parameters");
   end

   logic [CARRY_WIDTH-1:0] a_s;
   logic [OP_WIDTH-1:0]    b_s;
   logic [OP_WIDTH-1:0]    c_s;
   logic                   en_s;

`ifdef BIN_ADD_3X2_INREG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_s  <= '0;
         b_s  <= '0;
         c_s  <= '0;
         en_s <= 1'b0;
      end else begin
         a_s  <= in_a;
         b_s  <= in_b;
         c_s  <= in_c;
         en_s <= enable_bin;
      end
   end
`else
   assign a_s  = in_a;
   assign b_s  = in_b;
   assign c_s  = in_c;
   assign en_s = enable_bin;
`endif

   logic [SUM_WIDTH-1:0] x;
   logic [SUM_WIDTH-1:0] y;
   logic [SUM_WIDTH-1:0] z;
   logic [SUM_WIDTH-1:0] ps;
   logic [SUM_WIDTH-1:0] gc;
   logic [SUM_WIDTH-1:0] sum_nx;
   logic [SUM_WIDTH-1:0] sum_q;

   assign x = SUM_WIDTH'(a_s);
   assign y = en_s ? SUM_WIDTH'(b_s) : '0;
   assign z = SUM_WIDTH'(c_s);

   // 3:2 carry-save stage, then one carry-propagate add
   for (genvar k = 0; k < SUM_WIDTH; k++) begin : g_csa
      assign ps[k] = x[k] ^ y[k] ^ z[k];
      assign gc[k] = (x[k] & y[k]) | (x[k] & z[k])
                   | (y[k] & z[k]);
   end

   assign sum_nx = ps + (gc << 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_nx;
      end
   end

   assign low_sum = sum_q[OP_WIDTH-1:0];
   assign hi_sum  = sum_q[SUM_WIDTH-1:OP_WIDTH];

endmodule

// File: tb/tb_bin_add_3x2.sv
// tb_bin_add_3x2: directed table, streaming sweep and reset checks.
// Honours BIN_ADD_3X2_INREG_EN for the expected latency.
module tb_bin_add_3x2;

   localparam int OW = 16;
   localparam int CW = 1;
   localparam int SW = 17;
`ifdef BIN_ADD_3X2_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] in_a;
   logic [OW-1:0] in_b;
   logic [OW-1:0] in_c;
   logic          enable_bin;
   logic [OW-1:0] low_sum;
   logic [SW-OW-1:0] hi_sum;

   bin_add_3x2 #(
      .OP_WIDTH   (OW),
      .CARRY_WIDTH(CW),
      .SUM_WIDTH  (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .enable_bin(enable_bin),
      .low_sum   (low_sum),
      .hi_sum    (hi_sum)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [SW-1:0] exp_v   [LAT];
   logic          exp_ok  [LAT];
   string         exp_tag [LAT];

   typedef struct {
      logic [CW-1:0] a;
      logic [OW-1:0] b;
      logic [OW-1:0] c;
      logic          en;
      logic [OW-1:0] lo;
      logic          hi;
      string         name;
   } vec_t;

   vec_t tbl [11];

   function automatic logic [SW-1:0] model(
      input logic [CW-1:0] a,
      input logic [OW-1:0] b,
      input logic [OW-1:0] c,
      input logic          en
   );
      int unsigned s;
      s = int'(a) + (en ? int'(b) : 0) + int'(c);
      return SW'(s);
   endfunction

   // Drive one cycle; expected value emerges LAT edges later
   task automatic step(
      input logic          rst,
      input logic [CW-1:0] a,
      input logic [OW-1:0] b,
      input logic [OW-1:0] c,
      input logic          en,
      input logic [SW-1:0] exp,
      input logic          chk,
      input string         tag
   );
      rst_n      = rst;
      in_a       = a;
      in_b       = b;
      in_c       = c;
      enable_bin = en;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < LAT; i++) begin
            exp_v[i]   = '0;
            exp_ok[i]  = 1'b1;
            exp_tag[i] = {"reset/", tag};
         end
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            exp_v[i]   = exp_v[i-1];
            exp_ok[i]  = exp_ok[i-1];
            exp_tag[i] = exp_tag[i-1];
         end
         exp_v[0]   = exp;
         exp_ok[0]  = chk;
         exp_tag[0] = tag;
      end
      #1;
      if (exp_ok[LAT-1]) begin
         n_chk++;
         if ({hi_sum, low_sum} !== exp_v[LAT-1]) begin
            n_fail++;
            $display("FAIL %s: got hi=%0h lo=%04h, want hi=%0h lo=%04h",
                     exp_tag[LAT-1], hi_sum, low_sum,
                     exp_v[LAT-1][SW-1:OW], exp_v[LAT-1][OW-1:0]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) begin
         exp_v[i]   = '0;
         exp_ok[i]  = 1'b0;
         exp_tag[i] = "none";
      end

      tbl[0]  = '{1'b1, 16'h3F4E, 16'hDFEA, 1'b1, 16'h1F39, 1'b1, "basic"};
      tbl[1]  = '{1'b1, 16'h3F4E, 16'hDFEA, 1'b0, 16'hDFEB, 1'b0, "en_off"};
      tbl[2]  = '{1'b0, 16'h3F4E, 16'hDFEA, 1'b1, 16'h1F38, 1'b1, "a_zero"};
      tbl[3]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "max"};
      tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "zero"};
      tbl[5]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "a_only"};
      tbl[6]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, "bc_wrap"};
      tbl[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b1, "ac_wrap"};
      tbl[8]  = '{1'b0, 16'h1234, 16'h0001, 1'b1, 16'h1235, 1'b0, "small"};
      tbl[9]  = '{1'b1, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, "a_ripple"};
      tbl[10] = '{1'b0, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF, 1'b0, "alt_bits"};

      // Reset held with nonzero inputs: outputs must stay 0
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, '0, 1'b0, "rst_hold");
      for (int i = 0; i < LAT; i++)
         step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, '0, 1'b1, "post_rst");

      foreach (tbl[i])
         step(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].en,
              {tbl[i].hi, tbl[i].lo}, 1'b1, tbl[i].name);
      for (int i = 0; i < LAT; i++)
         step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, '0, 1'b1, "flush");

      // Back-to-back sweep with a one-edge reset in the middle
      for (int i = 32'h3DFE; i <= 32'hFFFE; i++) begin
         logic [CW-1:0] a;
         logic [OW-1:0] b;
         logic [OW-1:0] c;
         logic          r;
         a = CW'(i % 2);
         b = OW'(i + 1);
         c = OW'(i * 3);
         r = (i != 32'h8000);
         step(r, a, b, c, 1'b1, model(a, b, c, 1'b1), 1'b1,
              $sformatf("stream_%04h", i));
      end
      for (int i = 0; i < LAT; i++)
         step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, '0, 1'b1, "drain");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_add_3x2.md
BIN_ADD_3X2 -- requirements
Module: bin_add_3x2

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 16: width of summation operands in_b, in_c and of low_sum.
REQ-002 SHALL have parameter CARRY_WIDTH, default 1: width of the small carry operand in_a.
REQ-003 SHALL have parameter SUM_WIDTH, default 17: full result width; hi_sum carries bits SUM_WIDTH-1..OP_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_a, input, CARRY_WIDTH bits: small carry-in operand, zero-extended.
REQ-007 SHALL have port in_b, input, OP_WIDTH bits: conditional summation operand.
REQ-008 SHALL have port in_c, input, OP_WIDTH bits: unconditional summation operand.
REQ-009 SHALL have port enable_bin, input, 1 bit: 1 includes in_b in the sum; 0 replaces in_b with zero.
REQ-010 SHALL have port low_sum, output, OP_WIDTH bits: registered result bits OP_WIDTH-1..0.
REQ-011 SHALL have port hi_sum, output, SUM_WIDTH-OP_WIDTH bits: registered result bits SUM_WIDTH-1..OP_WIDTH.

Function
REQ-012 SHALL compute S = in_a + (enable_bin ? in_b : 0) + in_c, all operands zero-extended (unsigned).
REQ-013 SHALL truncate S modulo 2^SUM_WIDTH; with defaults the maximum 1+0xFFFF+0xFFFF = 0x1FFFF fits exactly, so no overflow.
REQ-014 SHALL register {hi_sum, low_sum} = S; latency 1 clock from input sampling edge to output, new result accepted every cycle, no handshake.
REQ-015 SHALL sample enable_bin on the same edge as the operands; enable_bin gates only in_b, never in_a or in_c.
REQ-016 SHALL hold outputs stable between rising edges; no combinational path from inputs to outputs.
REQ-017 SHALL require SUM_WIDTH > OP_WIDTH and CARRY_WIDTH <= OP_WIDTH; other values are unsupported.

Reset
REQ-018 SHALL clear low_sum and hi_sum (and every pipeline register) to 0 on any rising clk edge with rst_n = 0.
REQ-019 SHALL give reset priority over the input sampled on the same edge; the first valid result appears one cycle after the first edge with rst_n = 1 (two with the Configuration option enabled).
REQ-020 SHALL discard any in-flight result when reset is asserted mid-stream.

Configuration
REQ-021 SHALL honour macro BIN_ADD_3X2_INREG_EN: when defined, in_a, in_b, in_c and enable_bin are registered before the adder, giving latency 2; when undefined, latency is 1. The arithmetic result is identical in both builds.

Verification
REQ-022 SHALL check: in_a=1, in_b=0x3F4E, in_c=0xDFEA, enable_bin=1 -> low_sum=0x1F39, hi_sum=1 after the latency.
REQ-023 SHALL check: in_a=1, in_b=0x3F4E, in_c=0xDFEA, enable_bin=0 -> low_sum=0xDFEB, hi_sum=0.
REQ-024 SHALL check: in_a=0, in_b=0x3F4E, in_c=0xDFEA, enable_bin=1 -> low_sum=0x1F38, hi_sum=1.
REQ-025 SHALL check the maximum case: in_a=1, in_b=0xFFFF, in_c=0xFFFF, enable_bin=1 -> low_sum=0xFFFF, hi_sum=1; and all-zero inputs -> 0/0.
REQ-026 SHALL check back-to-back streaming for i = 0x3DFE..0xFFFE with in_a=i mod 2, in_b=i+1, in_c=(i*3) mod 2^16, enable_bin=1 -> each output equals the REQ-012 reference model, one result per cycle at the fixed latency.
REQ-027 SHALL check reset: assert rst_n=0 for one edge during the stream -> outputs 0 on the next cycle, and correct results resume after the latency.
